pipe_stage_reg: RTL and testbench

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 147 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: two-entry (main + skid) pipeline register with valid/ready
// handshaking, registered in_ready and synchronous flush.
// Optional feature: define PIPE_STAGE_STALL_CNT_EN to add the stall_cnt port
// and its saturating stall-cycle counter.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              flush
`ifdef PIPE_STAGE_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } state_t;

  state_t            state;
  state_t            next_state;
  logic              in_ready_q;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic [CTRL_W-1:0] skid_ctrl;

  logic in_xfer;
  logic out_xfer;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid;
  logic drain_main;

  // State register; in_ready is registered from the next state so it never
  // sees out_ready combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
    end else if (flush) begin
      state      <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= next_state;
      in_ready_q <= (next_state != FULL);
    end
  end

  // Next-state and entry-movement decode from the two handshakes.
  always_comb begin
    in_xfer        = in_valid & in_ready_q;
    out_xfer       = out_valid & out_ready;
    next_state     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    drain_main     = 1'b0;
    unique case (state)
      EMPTY: begin
        if (in_xfer) begin
          next_state   = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          load_main_in = 1'b1;
        end else if (out_xfer) begin
          next_state = EMPTY;
          drain_main = 1'b1;
        end else if (in_xfer) begin
          next_state = FULL;
          load_skid  = 1'b1;
        end
      end
      FULL: begin
        if (out_xfer) begin
          next_state     = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: next_state = EMPTY;
    endcase
  end

  // Outputs come straight from the main entry; ctrl is masked when invalid.
  always_comb begin
    out_valid = (state != EMPTY);
    out_data  = main_data;
    out_ctrl  = out_valid ? main_ctrl : '0;
    in_ready  = in_ready_q;
  end

  // Entry storage; flush clears ctrl but leaves data untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else if (flush) begin
      main_ctrl <= '0;
      skid_ctrl <= '0;
    end else begin
      if (load_main_in) begin
        main_data <= in_data;
        main_ctrl <= in_ctrl;
      end else if (load_main_skid) begin
        main_data <= skid_data;
        main_ctrl <= skid_ctrl;
      end else if (drain_main) begin
        main_ctrl <= '0;
      end
      if (load_skid) begin
        skid_data <= in_data;
        skid_ctrl <= in_ctrl;
      end else if (load_main_skid) begin
        skid_ctrl <= '0;
      end
    end
  end

`ifdef PIPE_STAGE_STALL_CNT_EN
  // Saturating count of cycles where the head entry is held by downstream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [7:0]  in_ctrl = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [7:0]  out_ctrl;
  logic        flush = 1'b0;
`ifdef PIPE_STAGE_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int vecs = 0;
  int errs = 0;

  pipe_stage_reg #(.DATA_W(16), .CTRL_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_ctrl(in_ctrl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_ctrl(out_ctrl),
    .flush(flush)
`ifdef PIPE_STAGE_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic [7:0]  c;
  } ent_t;

  ent_t        q[$];
  logic [15:0] m_stall = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO of depth 2 with pop-then-push per edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_stall = '0;
    end else begin
      bit ox;
      bit ix;
      ox = (q.size() > 0) && out_ready;
      ix = in_valid && (q.size() < 2);
      if ((q.size() > 0) && !out_ready && (m_stall != 16'hFFFF)) m_stall = m_stall + 16'd1;
      if (flush) begin
        q.delete();
      end else begin
        if (ox) void'(q.pop_front());
        if (ix) q.push_back({in_data, in_ctrl});
      end
    end
  end

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    chk("out_valid", {31'd0, out_valid}, {31'd0, q.size() > 0});
    chk("in_ready", {31'd0, in_ready}, {31'd0, q.size() < 2});
    chk("out_ctrl", {24'd0, out_ctrl}, (q.size() > 0) ? {24'd0, q[0].c} : 32'd0);
    if (q.size() > 0) chk("out_data", {16'd0, out_data}, {16'd0, q[0].d});
    else if (rst) chk("rst_data", {16'd0, out_data}, 32'd0);
`ifdef PIPE_STAGE_STALL_CNT_EN
    chk("stall_cnt", {16'd0, stall_cnt}, {16'd0, m_stall});
`endif
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic put(input logic v, input logic [15:0] d, input logic [7:0] c,
                     input logic ordy, input logic fl);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
  endtask

  initial begin
    repeat (2) tick();
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    rst = 1'b0;

    // Streaming back-to-back
    for (int i = 1; i <= 8; i++) begin
      put(1'b1, 16'(i), 8'(i), 1'b1, 1'b0);
      tick();
      chk("stream_data", {16'd0, out_data}, i);
      chk("stream_ready", {31'd0, in_ready}, 32'd1);
    end
    put(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    chk("stream_drain", {31'd0, out_valid}, 32'd0);

    // Backpressure into FULL, then release
    put(1'b1, 16'hAAAA, 8'h11, 1'b0, 1'b0);
    tick();
    put(1'b1, 16'hBBBB, 8'h22, 1'b0, 1'b0);
    tick();
    chk("bp_full_ready", {31'd0, in_ready}, 32'd0);
    put(1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    chk("bp_hold_head", {16'd0, out_data}, 32'h0000AAAA);
    put(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    chk("bp_second", {16'd0, out_data}, 32'h0000BBBB);
    chk("bp_ready_back", {31'd0, in_ready}, 32'd1);
    tick();
    chk("bp_empty", {31'd0, out_valid}, 32'd0);

    // Flush while FULL with an input offered
    put(1'b1, 16'h1111, 8'h33, 1'b0, 1'b0);
    tick();
    put(1'b1, 16'h2222, 8'h44, 1'b0, 1'b0);
    tick();
    put(1'b1, 16'hCCCC, 8'hFF, 1'b0, 1'b1);
    tick();
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_ctrl", {24'd0, out_ctrl}, 32'd0);
    chk("flush_ready", {31'd0, in_ready}, 32'd1);
    put(1'b0, '0, '0, 1'b1, 1'b0);
    repeat (3) begin
      tick();
      chk("flush_no_ghost", {31'd0, out_valid}, 32'd0);
    end

    // Asynchronous reset while FULL, checked before the next edge
    put(1'b1, 16'h3333, 8'h55, 1'b0, 1'b0);
    tick();
    put(1'b1, 16'h4444, 8'h66, 1'b0, 1'b0);
    tick();
    put(1'b0, '0, '0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_ctrl", {24'd0, out_ctrl}, 32'd0);
    tick();
    rst = 1'b0;
    put(1'b1, 16'h5A5A, 8'h81, 1'b0, 1'b0);
    tick();
    chk("first_after_rst", {16'd0, out_data}, 32'h00005A5A);

    // Simultaneous in/out while ONE
    put(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    put(1'b1, 16'h1111, 8'h01, 1'b0, 1'b0);
    tick();
    put(1'b1, 16'h1234, 8'h02, 1'b1, 1'b0);
    tick();
    chk("sim_data", {16'd0, out_data}, 32'h00001234);
    chk("sim_ready", {31'd0, in_ready}, 32'd1);
    put(1'b0, '0, '0, 1'b1, 1'b0);
    tick();
    chk("sim_skid_empty", {31'd0, out_valid}, 32'd0);

`ifdef PIPE_STAGE_STALL_CNT_EN
    // Saturation of the stall counter, and flush leaves it alone
    put(1'b1, 16'h7777, 8'h07, 1'b0, 1'b0);
    tick();
    put(1'b0, '0, '0, 1'b0, 1'b0);
    repeat (70000) tick();
    chk("stall_sat", {16'd0, stall_cnt}, 32'h0000FFFF);
    put(1'b0, '0, '0, 1'b0, 1'b1);
    tick();
    flush = 1'b0;
    tick();
    chk("stall_after_flush", {16'd0, stall_cnt}, 32'h0000FFFF);
`endif

    // Randomized traffic
    for (int n = 0; n < 500; n++) begin
      put(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom),
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0));
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    put(1'b0, '0, '0, 1'b1, 1'b0);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
